// File: rtl/ahb_slave_if.sv
// rtl/ahb_slave_if.sv - AHB slave front end: 3-region decode, address/data pipeline, transfer counter.
// Define AHB_ERR_RESP_EN to build in the two-cycle ERROR response for unmapped transfers.
module ahb_slave_if #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned REGION_LOG2 = 26
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic        cnt_clr,
  output logic        valid,
  output logic [2:0]  tempselx,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [31:0] Hwdata2,
  output logic        Hwritereg,
  output logic [1:0]  Hresp,
  output logic        err_stall,
  output logic [15:0] xfer_cnt
);

  logic        active;
  logic [32:0] offset;
  logic [31:0] region_idx;
  logic        unused_htrans0;

  logic [31:0] haddr1_q, haddr2_q, hwdata1_q, hwdata2_q;
  logic        hwrite_q;
  logic [15:0] xfer_cnt_q, xfer_cnt_d;
  logic [1:0]  hresp_q;
  logic        err_stall_q;

  assign unused_htrans0 = Htrans[0];
  assign active         = Hreadyin & Htrans[1];

  // Borrow out of the 33-bit subtract flags addresses below BASE_ADDR.
  assign offset     = {1'b0, Haddr} - {1'b0, BASE_ADDR};
  assign region_idx = offset[31:0] >> REGION_LOG2;

  always_comb begin
    tempselx = 3'b000;
    if (!offset[32]) begin
      case (region_idx)
        32'd0:   tempselx = 3'b001;
        32'd1:   tempselx = 3'b010;
        32'd2:   tempselx = 3'b100;
        default: tempselx = 3'b000;
      endcase
    end
  end

  assign valid = active & (tempselx != 3'b000) & ~err_stall;

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      haddr1_q  <= 32'h0;
      haddr2_q  <= 32'h0;
      hwdata1_q <= 32'h0;
      hwdata2_q <= 32'h0;
      hwrite_q  <= 1'b0;
    end else begin
      haddr1_q  <= Haddr;
      haddr2_q  <= haddr1_q;
      hwdata1_q <= Hwdata;
      hwdata2_q <= hwdata1_q;
      hwrite_q  <= Hwrite;
    end
  end

  assign Haddr1    = haddr1_q;
  assign Haddr2    = haddr2_q;
  assign Hwdata1   = hwdata1_q;
  assign Hwdata2   = hwdata2_q;
  assign Hwritereg = hwrite_q;

  // Clear wins over increment; the counter sticks at all-ones.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (cnt_clr) begin
      xfer_cnt_d = 16'h0;
    end else if (valid && (xfer_cnt_q != 16'hFFFF)) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      xfer_cnt_q <= 16'h0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;

`ifdef AHB_ERR_RESP_EN
  typedef enum logic [1:0] {ERR_IDLE, ERR_1, ERR_2} err_state_e;
  err_state_e err_state_q;

  // Unmapped transfers seen outside ERR_IDLE are dropped; the master cancels during ERR_2.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      err_state_q <= ERR_IDLE;
      hresp_q     <= 2'b00;
      err_stall_q <= 1'b0;
    end else begin
      case (err_state_q)
        ERR_IDLE: begin
          if (active && (tempselx == 3'b000)) begin
            err_state_q <= ERR_1;
            hresp_q     <= 2'b01;
            err_stall_q <= 1'b1;
          end
        end
        ERR_1: begin
          err_state_q <= ERR_2;
          hresp_q     <= 2'b01;
          err_stall_q <= 1'b0;
        end
        default: begin
          err_state_q <= ERR_IDLE;
          hresp_q     <= 2'b00;
          err_stall_q <= 1'b0;
        end
      endcase
    end
  end
`else
  assign hresp_q     = 2'b00;
  assign err_stall_q = 1'b0;
`endif

  assign Hresp     = hresp_q;
  assign err_stall = err_stall_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// tb/tb_ahb_slave_if.sv - randomized scoreboard bench for ahb_slave_if against a behavioural model.
module tb_ahb_slave_if;

  localparam longint BASE   = 64'h8000_0000;
  localparam longint REGION = 64'h0400_0000;
`ifdef AHB_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic        Hclk = 1'b0;
  logic        Hreset = 1'b1;
  logic        Hwrite = 1'b0;
  logic        Hreadyin = 1'b0;
  logic [1:0]  Htrans = 2'b00;
  logic [31:0] Haddr = 32'h0;
  logic [31:0] Hwdata = 32'h0;
  logic        cnt_clr = 1'b0;
  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2;
  logic        Hwritereg;
  logic [1:0]  Hresp;
  logic        err_stall;
  logic [15:0] xfer_cnt;

  ahb_slave_if dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .cnt_clr(cnt_clr),
    .valid(valid), .tempselx(tempselx), .Haddr1(Haddr1), .Haddr2(Haddr2),
    .Hwdata1(Hwdata1), .Hwdata2(Hwdata2), .Hwritereg(Hwritereg),
    .Hresp(Hresp), .err_stall(err_stall), .xfer_cnt(xfer_cnt)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    logic        valid;
    logic [2:0]  sel;
    logic [31:0] a1, a2, d1, d2;
    logic        wr;
    logic [1:0]  resp;
    logic        stall;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: values visible after the most recent clock edge.
  logic [31:0] m_a1 = 0, m_a2 = 0, m_d1 = 0, m_d2 = 0;
  logic        m_wr = 0;
  int          m_cnt = 0;
  int          m_err_left = 0;

  function automatic int region_of(input logic [31:0] a);
    longint off;
    off = longint'({32'h0, a}) - BASE;
    if (off < 0 || off >= 3 * REGION) return -1;
    return int'(off / REGION);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic wr, input logic rdy, input logic [1:0] tr,
                       input logic [31:0] a, input logic [31:0] d, input logic clr);
    exp_t e;
    int   r;
    logic act, v;
    @(posedge Hclk);
    #1;
    Hreset = rst; Hwrite = wr; Hreadyin = rdy; Htrans = tr; Haddr = a; Hwdata = d; cnt_clr = clr;
    if (rst) begin
      m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0; m_wr = 0; m_cnt = 0; m_err_left = 0;
    end
    r   = region_of(a);
    act = rdy && tr[1];
    v   = act && (r >= 0) && (m_err_left != 2);
    e.valid = v;
    e.sel   = (r == 0) ? 3'b001 : (r == 1) ? 3'b010 : (r == 2) ? 3'b100 : 3'b000;
    e.a1 = m_a1; e.a2 = m_a2; e.d1 = m_d1; e.d2 = m_d2; e.wr = m_wr;
    e.resp  = (m_err_left > 0) ? 2'b01 : 2'b00;
    e.stall = (m_err_left == 2);
    e.cnt   = 16'(m_cnt);
    sb.push_back(e);
    if (rst) begin
      m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0; m_wr = 0; m_cnt = 0; m_err_left = 0;
    end else begin
      m_a2 = m_a1; m_a1 = a; m_d2 = m_d1; m_d1 = d; m_wr = wr;
      if (clr) m_cnt = 0;
      else if (v && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_err_left > 0) m_err_left = m_err_left - 1;
      else if (ERR_EN && act && r < 0) m_err_left = 2;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8BFF_FFFF;
      2:       return 32'h8C00_0000;
      3:       return $urandom();
      4:       return 32'h83FF_FFFC + 32'($urandom_range(0, 1) * 4);
      default: return 32'(BASE + longint'($urandom_range(0, 2)) * REGION + longint'($urandom_range(0, 32'h03FF_FFFF)));
    endcase
  endfunction

  always @(negedge Hclk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("valid",     {31'b0, valid},     {31'b0, mon_e.valid});
      check("tempselx",  {29'b0, tempselx},  {29'b0, mon_e.sel});
      check("Haddr1",    Haddr1,             mon_e.a1);
      check("Haddr2",    Haddr2,             mon_e.a2);
      check("Hwdata1",   Hwdata1,            mon_e.d1);
      check("Hwdata2",   Hwdata2,            mon_e.d2);
      check("Hwritereg", {31'b0, Hwritereg}, {31'b0, mon_e.wr});
      check("Hresp",     {30'b0, Hresp},     {30'b0, mon_e.resp});
      check("err_stall", {31'b0, err_stall}, {31'b0, mon_e.stall});
      check("xfer_cnt",  {16'b0, xfer_cnt},  {16'b0, mon_e.cnt});
    end
  end

  initial begin
    repeat (3) drive(1, $urandom_range(0, 1), 1, NONSEQ, rand_addr(), $urandom(), 0);
    drive(0, 1, 1, NONSEQ, 32'h8000_0010, 32'hA5A5_0001, 0);
    drive(0, 0, 1, SEQ,    32'h8400_0000, $urandom(), 0);
    drive(0, 0, 1, SEQ,    32'h8800_0004, $urandom(), 0);
    drive(0, 0, 1, BUSY,   32'h8000_0020, $urandom(), 0);
    drive(0, 0, 1, IDLE,   32'h8000_0020, $urandom(), 0);
    drive(0, 1, 0, NONSEQ, 32'h8400_0040, $urandom(), 0);
    drive(0, 1, 1, NONSEQ, 32'h9000_0000, $urandom(), 0);
    drive(0, 0, 1, IDLE,   32'h9000_0000, $urandom(), 0);
    drive(0, 0, 1, IDLE,   32'h8000_0000, $urandom(), 0);
    drive(0, 0, 1, IDLE,   32'h8000_0000, $urandom(), 0);
    drive(0, 1, 1, NONSEQ, 32'h7000_0000, $urandom(), 0);
    drive(0, 1, 1, NONSEQ, 32'h8000_0100, $urandom(), 0);
    drive(0, 1, 1, NONSEQ, 32'hF000_0000, $urandom(), 0);
    drive(0, 0, 1, IDLE,   32'h0,         $urandom(), 0);
    drive(0, 0, 1, IDLE,   32'h0,         $urandom(), 0);
    for (int i = 0; i < 400; i++)
      drive(0, $urandom_range(0, 1), ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
            rand_addr(), $urandom(), ($urandom_range(0, 30) == 0));
    drive(0, 0, 1, IDLE, 32'h0, 32'h0, 1);
    for (int i = 0; i < 65540; i++)
      drive(0, 1, 1, NONSEQ, 32'(BASE + longint'($urandom_range(0, 32'h0BFF_FFFF))), $urandom(), 0);
    drive(0, 1, 1, NONSEQ, 32'h8000_0004, $urandom(), 1);
    drive(0, 0, 1, IDLE,   32'h0,         $urandom(), 0);
    drive(0, 1, 1, NONSEQ, 32'h8400_0008, $urandom(), 0);
    drive(0, 1, 1, NONSEQ, 32'h9000_0000, $urandom(), 0);
    drive(1, 0, 1, IDLE,   32'h9000_0000, $urandom(), 0);
    drive(0, 0, 1, IDLE,   32'h8000_0000, $urandom(), 0);
    drive(0, 1, 1, NONSEQ, 32'h8800_0000, $urandom(), 0);
    drive(0, 0, 0, IDLE,   32'h0,         $urandom(), 0);
    repeat (2) @(negedge Hclk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
